// File: rtl/tank_pkg.sv
// Shared types for the per-tank movement controller.
// Direction encoding, FSM states and step deltas.
package tank_pkg;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    STAND = 3'd4
  } dir_e;

  typedef enum logic {
    S_COUNT = 1'b0,
    S_REQ   = 1'b1
  } mv_state_e;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  function automatic delta_t step_delta(input dir_e d);
    delta_t r;
    r = '0;
    case (d)
      UP:      r.dy = 2'sd1;
      DOWN:    r.dy = -2'sd1;
      LEFT:    r.dx = -2'sd1;
      RIGHT:   r.dx = 2'sd1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tank_step_calc.sv
// Combinational one-cell step: candidate position and arena check.
// One extra bit exposes underflow below 0 and overflow past the range.
module tank_step_calc
  import tank_pkg::*;
#(
  parameter int COORD_W = 6,
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MARGIN  = 1
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  dir_e               dir_i,
  output logic [COORD_W-1:0] cand_x_o,
  output logic [COORD_W-1:0] cand_y_o,
  output logic               in_bounds_o
);

  localparam logic [COORD_W-1:0] LO   = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] HI_X = COORD_W'(GRID_W - 1 - MARGIN);
  localparam logic [COORD_W-1:0] HI_Y = COORD_W'(GRID_H - 1 - MARGIN);

  delta_t d;
  logic [COORD_W:0] nx;
  logic [COORD_W:0] ny;

  always_comb begin
    d  = step_delta(dir_i);
    nx = {1'b0, x_i} + {{(COORD_W-1){d.dx[1]}}, d.dx};
    ny = {1'b0, y_i} + {{(COORD_W-1){d.dy[1]}}, d.dy};
  end

  assign cand_x_o = nx[COORD_W-1:0];
  assign cand_y_o = ny[COORD_W-1:0];

  assign in_bounds_o = !nx[COORD_W] && !ny[COORD_W]
                    && (cand_x_o >= LO) && (cand_x_o <= HI_X)
                    && (cand_y_o >= LO) && (cand_y_o <= HI_Y);

endmodule

// File: rtl/tank_mover.sv
// Per-tank movement controller: counts held frames, proposes a step,
// and commits it only after Game returns an unblocked verdict.
module tank_mover
  import tank_pkg::*;
#(
  parameter int COORD_W     = 6,
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MARGIN      = 1,
  parameter int HOLD_FRAMES = 5,
  parameter int INIT_X      = 2,
  parameter int INIT_Y      = 2,
  parameter int INIT_DIR    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               respawn,
  input  logic [COORD_W-1:0] initial_x,
  input  logic [COORD_W-1:0] initial_y,
  input  logic [1:0]         initial_direction,
  input  logic [2:0]         direction_in,
  input  logic               valid_take_direction,
  output logic               move_req,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y,
  input  logic               move_ack,
  input  logic               move_blocked,
  output logic [COORD_W-1:0] tank_x_pos,
  output logic [COORD_W-1:0] tank_y_pos,
  output logic [1:0]         direction_out,
  output logic               moved
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_FRAMES - 1);

  mv_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  dir_e               last_q, last_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0]         face_q, face_d;
  logic               req_q, req_d;
  logic               moved_q, moved_d;

  dir_e               dir_n;
  logic [COORD_W-1:0] step_x, step_y;
  logic               step_ok;

  // Codes 5-7 are folded onto STAND
  assign dir_n = (direction_in > 3'd4) ? STAND : dir_e'(direction_in);

  tank_step_calc #(
    .COORD_W (COORD_W),
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MARGIN  (MARGIN)
  ) u_calc (
    .x_i         (x_q),
    .y_i         (y_q),
    .dir_i       (dir_n),
    .cand_x_o    (step_x),
    .cand_y_o    (step_y),
    .in_bounds_o (step_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COUNT;
      cnt_q   <= '0;
      last_q  <= STAND;
      x_q     <= COORD_W'(INIT_X);
      y_q     <= COORD_W'(INIT_Y);
      cx_q    <= '0;
      cy_q    <= '0;
      face_q  <= 2'(INIT_DIR);
      req_q   <= 1'b0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      face_q  <= face_d;
      req_q   <= req_d;
      moved_q <= moved_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    face_d  = face_q;
    req_d   = req_q;
    moved_d = 1'b0;
    if (respawn) begin
      x_d     = initial_x;
      y_d     = initial_y;
      face_d  = initial_direction;
      cnt_d   = '0;
      last_d  = STAND;
      req_d   = 1'b0;
      state_d = S_COUNT;
    end else begin
      case (state_q)
        S_COUNT: begin
          if (valid_take_direction) begin
            if (dir_n == STAND || dir_n != last_q) begin
              last_d = dir_n;
              cnt_d  = '0;
            end else if (cnt_q < CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              // Facing turns even if the step is clamped
              cnt_d  = '0;
              face_d = dir_n[1:0];
              if (step_ok) begin
                cx_d    = step_x;
                cy_d    = step_y;
                req_d   = 1'b1;
                state_d = S_REQ;
              end
            end
          end
        end
        S_REQ: begin
          if (move_ack) begin
            req_d   = 1'b0;
            state_d = S_COUNT;
            if (!move_blocked) begin
              x_d     = cx_q;
              y_d     = cy_q;
              moved_d = 1'b1;
            end
          end
        end
        default: state_d = S_COUNT;
      endcase
    end
  end

  assign move_req      = req_q;
  assign cand_x        = cx_q;
  assign cand_y        = cy_q;
  assign tank_x_pos    = x_q;
  assign tank_y_pos    = y_q;
  assign direction_out = face_q;
  assign moved         = moved_q;

endmodule

// File: tb/tb_tank_mover.sv
// Directed bench for tank_mover with a commit scoreboard.
// Expected positions are queued at ack time and popped on moved.
module tb_tank_mover;
  import tank_pkg::*;

  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          respawn = 1'b0;
  logic [CW-1:0] initial_x = '0;
  logic [CW-1:0] initial_y = '0;
  logic [1:0]    initial_direction = '0;
  logic [2:0]    direction_in = 3'd4;
  logic          valid_take_direction = 1'b0;
  logic          move_req;
  logic [CW-1:0] cand_x, cand_y;
  logic          move_ack = 1'b0;
  logic          move_blocked = 1'b0;
  logic [CW-1:0] tank_x_pos, tank_y_pos;
  logic [1:0]    direction_out;
  logic          moved;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
  } pos_t;
  pos_t exp_q[$];

  tank_mover dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .respawn              (respawn),
    .initial_x            (initial_x),
    .initial_y            (initial_y),
    .initial_direction    (initial_direction),
    .direction_in         (direction_in),
    .valid_take_direction (valid_take_direction),
    .move_req             (move_req),
    .cand_x               (cand_x),
    .cand_y               (cand_y),
    .move_ack             (move_ack),
    .move_blocked         (move_blocked),
    .tank_x_pos           (tank_x_pos),
    .tank_y_pos           (tank_y_pos),
    .direction_out        (direction_out),
    .moved                (moved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    pos_t p;
    if (rst_n && moved === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("moved_unexpected", 32'd1, 32'd0);
      end else begin
        p = exp_q.pop_front();
        chk("commit_x", 32'(tank_x_pos), p.x);
        chk("commit_y", 32'(tank_y_pos), p.y);
      end
    end
  end

  task automatic strobe(input logic [2:0] d);
    @(negedge clk);
    direction_in = d;
    valid_take_direction = 1'b1;
    @(negedge clk);
    valid_take_direction = 1'b0;
  endtask

  task automatic strobes(input logic [2:0] d, input int n);
    for (int i = 0; i < n; i++) strobe(d);
  endtask

  task automatic respawn_to(input int x, input int y, input int d);
    @(negedge clk);
    respawn = 1'b1;
    initial_x = CW'(x);
    initial_y = CW'(y);
    initial_direction = 2'(d);
    @(negedge clk);
    respawn = 1'b0;
  endtask

  task automatic do_ack(input bit blk, input int dly,
                        input int ex, input int ey);
    int n;
    n = 0;
    while (move_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(move_req), 32'd1);
    repeat (dly) @(negedge clk);
    if (!blk) exp_q.push_back('{ex, ey});
    move_ack = 1'b1;
    move_blocked = blk;
    @(negedge clk);
    move_ack = 1'b0;
    move_blocked = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_x", 32'(tank_x_pos), 32'd2);
    chk("rst_y", 32'(tank_y_pos), 32'd2);
    chk("rst_dir", 32'(direction_out), 32'd0);
    chk("rst_req", 32'(move_req), 32'd0);
    chk("rst_moved", 32'(moved), 32'd0);
    chk("rst_cand_x", 32'(cand_x), 32'd0);
    chk("rst_cand_y", 32'(cand_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: six RIGHT frames, immediate unblocked ack
    strobes(3'd3, 5);
    chk("t1_no_req_early", 32'(move_req), 32'd0);
    strobe(3'd3);
    chk("t1_req", 32'(move_req), 32'd1);
    chk("t1_cand_x", 32'(cand_x), 32'd3);
    chk("t1_cand_y", 32'(cand_y), 32'd2);
    chk("t1_dir", 32'(direction_out), 32'd3);
    chk("t1_x_before", 32'(tank_x_pos), 32'd2);
    do_ack(1'b0, 0, 3, 2);
    chk("t1_x", 32'(tank_x_pos), 32'd3);
    chk("t1_req_drop", 32'(move_req), 32'd0);
    @(negedge clk);
    chk("t1_moved_once", 32'(moved), 32'd0);

    // 2: a direction change discards the partial RIGHT count
    respawn_to(2, 2, 0);
    strobes(3'd3, 3);
    strobes(3'd0, 5);
    chk("t2_no_req", 32'(move_req), 32'd0);
    strobe(3'd0);
    chk("t2_cand_x", 32'(cand_x), 32'd2);
    chk("t2_cand_y", 32'(cand_y), 32'd3);
    do_ack(1'b0, 0, 2, 3);
    chk("t2_y", 32'(tank_y_pos), 32'd3);
    chk("t2_dir", 32'(direction_out), 32'd0);

    // 3: clamp at both x edges, facing still turns
    respawn_to(1, 5, 0);
    strobes(3'd2, 6);
    chk("t3_no_req_lo", 32'(move_req), 32'd0);
    chk("t3_x_lo", 32'(tank_x_pos), 32'd1);
    chk("t3_dir_lo", 32'(direction_out), 32'd2);
    respawn_to(38, 5, 0);
    strobes(3'd3, 6);
    chk("t3_no_req_hi", 32'(move_req), 32'd0);
    chk("t3_x_hi", 32'(tank_x_pos), 32'd38);
    chk("t3_dir_hi", 32'(direction_out), 32'd3);

    // 4: long wait with ignored strobes, then blocked verdict
    respawn_to(2, 2, 0);
    strobes(3'd1, 6);
    chk("t4_req", 32'(move_req), 32'd1);
    chk("t4_cand_y", 32'(cand_y), 32'd1);
    strobes(3'd1, 3);
    repeat (4) @(negedge clk);
    chk("t4_req_held", 32'(move_req), 32'd1);
    chk("t4_cand_stable", 32'(cand_y), 32'd1);
    do_ack(1'b1, 0, 0, 0);
    chk("t4_x", 32'(tank_x_pos), 32'd2);
    chk("t4_y", 32'(tank_y_pos), 32'd2);
    chk("t4_dir", 32'(direction_out), 32'd1);
    chk("t4_req_drop", 32'(move_req), 32'd0);
    strobes(3'd1, 4);
    chk("t4_cnt_zero", 32'(move_req), 32'd0);
    strobe(3'd1);
    chk("t4_req_again", 32'(move_req), 32'd1);
    do_ack(1'b0, 2, 2, 1);
    chk("t4_y_moved", 32'(tank_y_pos), 32'd1);

    // 5: respawn wins over a simultaneous ack
    strobes(3'd0, 6);
    chk("t5_req", 32'(move_req), 32'd1);
    @(negedge clk);
    respawn = 1'b1;
    initial_x = CW'(10);
    initial_y = CW'(10);
    initial_direction = 2'd3;
    move_ack = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    move_ack = 1'b0;
    chk("t5_x", 32'(tank_x_pos), 32'd10);
    chk("t5_y", 32'(tank_y_pos), 32'd10);
    chk("t5_dir", 32'(direction_out), 32'd3);
    chk("t5_req", 32'(move_req), 32'd0);
    chk("t5_moved", 32'(moved), 32'd0);

    // 6: code 7 acts as STAND, then async reset mid-request
    strobes(3'd3, 3);
    strobe(3'd7);
    strobes(3'd3, 5);
    chk("t6_no_req", 32'(move_req), 32'd0);
    strobe(3'd3);
    chk("t6_req", 32'(move_req), 32'd1);
    chk("t6_cand_x", 32'(cand_x), 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(move_req), 32'd0);
    chk("t6_rst_x", 32'(tank_x_pos), 32'd2);
    chk("t6_rst_y", 32'(tank_y_pos), 32'd2);
    chk("t6_rst_dir", 32'(direction_out), 32'd0);
    chk("t6_rst_cand", 32'(cand_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_commit", 32'(tank_x_pos), 32'd2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
